muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide engine that produces the HI and LO register write requests for MULT, MULTU, DIV and DIVU. It sits in the execute stage beside the ALU. It accepts one operation at a time through a start/busy handshake and, on completion, issues a single-cycle write pulse with 32-bit data to each of the HI and LO registers. The pipeline stalls on `busy` and flushes an in-flight operation with `cancel`.

## Interface
- `DIV_ITERS`, default 32: radix-2 divide iterations; fixed at the operand width. Any other value is unsupported.

- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high; clears all state and outputs.
- `start` in 1: request a new operation; sampled only when `busy`=0.
- `op` in 2: 00 = MULT, 01 = MULTU, 10 = DIV, 11 = DIVU; sampled with `start`.
- `src_a` in 32: multiplicand or dividend (rs).
- `src_b` in 32: multiplier or divisor (rt).
- `cancel` in 1: flush; aborts any operation and suppresses a pending write.
- `busy` out 1: an operation is in progress; no new start is accepted.
- `done` out 1: single-cycle completion pulse.
- `hi_w_en` out 1: HI write strobe.
- `lo_w_en` out 1: LO write strobe.
- `hi_w_data` out 32: value to write into HI.
- `lo_w_data` out 32: value to write into LO.

## Operation
- **States:** IDLE, DIV, DONE.
  - `busy` = (state == DIV).
  - `done` = `hi_w_en` = `lo_w_en` = (state == DONE) && !`cancel`.
- **IDLE or DONE, `start`=1, `cancel`=0:** capture `op`, `src_a` and `src_b`.
  - MULT/MULTU: compute the 64-bit product in the same cycle and register {HI, LO}; next state DONE.
    - MULT: signed × signed.
    - MULTU: unsigned × unsigned.
  - DIV/DIVU with `src_b`=0: HI=`src_a`, LO=0xFFFFFFFF; next state DONE.
  - DIV/DIVU otherwise: load the dividend magnitude, divisor magnitude, remainder=0 and iteration counter=0; next state DIV.
    - DIV uses two's-complement magnitudes; DIVU uses raw values.
    - Record the signs for DIV.
- **DIV state:** one restoring step per cycle.
  - Shift {rem, quot} left by 1.
  - If rem ≥ divisor: subtract the divisor and set the quotient LSB.
  - Increment the counter.
  - After the step with counter == DIV_ITERS−1, apply signs (DIV only) and go to DONE.
    - Quotient is negated if sign(a) XOR sign(b).
    - Remainder is negated if sign(a).
  - 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0. This is the natural wrap; no trap.
- **DONE state:** outputs present the result for one cycle. Next state is IDLE, unless a new `start` is accepted in the same cycle (back-to-back allowed).
- **`start` while `busy`=1:** ignored. The operand registers do not change.
- **`cancel`:** highest priority after `reset`.
  - Next state IDLE.
  - Write strobes and `done` are forced to 0 in the same cycle.
  - A `start` in the same cycle is ignored.
- **Result data:** `hi_w_data`/`lo_w_data` hold the last result and are stable outside DONE. Consumers qualify them with the strobes only.

## Timing
- **Reset:** state IDLE.
  - `busy`, `done`, `hi_w_en` and `lo_w_en` = 0.
  - `hi_w_data` and `lo_w_data` = 0x00000000.
  - Counter and operands cleared.
- **Multiply accepted in cycle N:** strobes are high in cycle N+1 only; `busy` is never asserted.
- **Divide by zero accepted in cycle N:** strobes are high in cycle N+1; `busy` is never asserted.
- **Divide accepted in cycle N:**
  - `busy`=1 in cycles N+1 … N+32.
  - Strobes and `done` are high in cycle N+33.
  - `busy`=0 in cycle N+33.
- **Strobe data:** HI and LO strobes always assert together, with data valid in the same cycle.
- **`reset` mid-divide:** the next cycle is IDLE, with no write pulse ever issued for the aborted operation.
- **Back-to-back:** a `start` in a DONE cycle N' gives its own result at N'+1 for a multiply or N'+33 for a divide.

## Test plan
- **MULTU:** 0xFFFFFFFF × 0xFFFFFFFF started at N → cycle N+1: HI=0xFFFFFFFE, LO=0x00000001, both strobes=1, `busy` low throughout.
- **MULT:** 0xFFFFFFFE (−2) × 0x00000003 → HI=0xFFFFFFFF, LO=0xFFFFFFFA at N+1.
- **DIV:** 0xFFFFFFF9 (−7) / 0x00000002 → `busy` high N+1..N+32; at N+33 LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - A `start` with MULTU at N+5 is ignored: no strobe at N+6, and the result is unchanged.
- **Divide edge cases:**
  - DIVU 0x00000064 / 0 → HI=0x00000064, LO=0xFFFFFFFF at N+1.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0x00000000 at N+33.
- **`cancel` during divide:** DIVU 100/7 with `cancel` at N+10 → `busy`=0 from N+11, no strobe through N+40.
- **`cancel` in the DONE cycle:** suppresses the strobes.
- **`reset` mid-divide:** `reset` at N+20 → all outputs 0 at N+21, no strobe afterwards.
- **Back-to-back:** DIVU 100/7 then MULTU 3×4 started in the DONE cycle →
  - HI=2, LO=14 at N+33.
  - HI=0, LO=12 at N+34.

Source files
------------

// File: rtl/muldiv_if.sv
// Handshake and HI/LO write-request bundle between the execute stage and the
// iterative multiply/divide engine.
interface muldiv_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        cancel;
   logic        busy;
   logic        done;
   logic        hi_w_en;
   logic        lo_w_en;
   logic [31:0] hi_w_data;
   logic [31:0] lo_w_data;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  busy, done, hi_w_en, lo_w_en, hi_w_data, lo_w_data
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output busy, done, hi_w_en, lo_w_en, hi_w_data, lo_w_data
   );
endinterface

// File: rtl/muldiv_unit.sv
// MULT/MULTU in a single cycle, DIV/DIVU by restoring radix-2 division over
// DIV_ITERS cycles; results leave as paired HI/LO write pulses.
module muldiv_unit #(
   parameter int DIV_ITERS = 32
) (
   input logic      clk,
   input logic      reset,
   muldiv_if.slave  bus
);

   localparam int CNT_W = $clog2(DIV_ITERS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_e;
   typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01,
                             OP_DIV  = 2'b10, OP_DIVU  = 2'b11} op_e;

   state_e           state_q, state_d;
   op_e              op_in;
   logic             accept;
   logic             div_last;
   logic [31:0]      hi_q, lo_q;
   logic [31:0]      rem_q, quot_q, divisor_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_quot_q, neg_rem_q;

   logic [63:0]      prod_s, prod_u;
   logic [31:0]      a_mag, b_mag;
   logic [32:0]      rem_shift;
   logic [31:0]      rem_next, quot_next;
   logic [31:0]      quot_final, rem_final;

   assign op_in = op_e'(bus.op);

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      accept        = 1'b0;
      div_last      = 1'b0;
      bus.busy      = (state_q == S_DIV);
      bus.done      = (state_q == S_DONE) && !bus.cancel;
      bus.hi_w_en   = (state_q == S_DONE) && !bus.cancel;
      bus.lo_w_en   = (state_q == S_DONE) && !bus.cancel;
      bus.hi_w_data = hi_q;
      bus.lo_w_data = lo_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (bus.start) begin
               accept  = 1'b1;
               state_d = (op_in[1] && bus.src_b != 32'd0) ? S_DIV : S_DONE;
            end
         end
         S_DIV: begin
            if (cnt_q == LAST_CNT) begin
               div_last = 1'b1;
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // Flush wins over any start or completion in the same cycle.
      if (bus.cancel) begin
         state_d  = S_IDLE;
         accept   = 1'b0;
         div_last = 1'b0;
      end
   end

   always_comb begin
      prod_s = $signed({{32{bus.src_a[31]}}, bus.src_a}) *
               $signed({{32{bus.src_b[31]}}, bus.src_b});
      prod_u = {32'd0, bus.src_a} * {32'd0, bus.src_b};
      a_mag  = (op_in == OP_DIV && bus.src_a[31]) ? -bus.src_a : bus.src_a;
      b_mag  = (op_in == OP_DIV && bus.src_b[31]) ? -bus.src_b : bus.src_b;

      // One restoring step: the partial remainder can briefly need 33 bits.
      rem_shift = {rem_q, quot_q[31]};
      quot_next = {quot_q[30:0], 1'b0};
      rem_next  = rem_shift[31:0];
      if (rem_shift >= {1'b0, divisor_q}) begin
         rem_next     = rem_shift[31:0] - divisor_q;
         quot_next[0] = 1'b1;
      end
      quot_final = neg_quot_q ? -quot_next : quot_next;
      rem_final  = neg_rem_q  ? -rem_next  : rem_next;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q       <= '0;
         lo_q       <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         divisor_q  <= '0;
         cnt_q      <= '0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
      end else if (accept) begin
         unique case (op_in)
            OP_MULT:  {hi_q, lo_q} <= prod_s;
            OP_MULTU: {hi_q, lo_q} <= prod_u;
            default: begin
               if (bus.src_b == 32'd0) begin
                  hi_q <= bus.src_a;
                  lo_q <= '1;
               end else begin
                  rem_q      <= '0;
                  quot_q     <= a_mag;
                  divisor_q  <= b_mag;
                  cnt_q      <= '0;
                  neg_quot_q <= (op_in == OP_DIV) && (bus.src_a[31] ^ bus.src_b[31]);
                  neg_rem_q  <= (op_in == OP_DIV) && bus.src_a[31];
               end
            end
         endcase
      end else if (state_q == S_DIV && !bus.cancel) begin
         rem_q  <= rem_next;
         quot_q <= quot_next;
         cnt_q  <= cnt_q + CNT_W'(1);
         if (div_last) begin
            hi_q <= rem_final;
            lo_q <= quot_final;
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference
// model of MULT/MULTU/DIV/DIVU and the start/busy/cancel timing.
module tb_muldiv_unit;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   inject_k;

   muldiv_if bus ();

   muldiv_unit #(.DIV_ITERS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected {HI, LO} from plain integer arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [31:0] uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin
            q = sa * sb;
            return q;
         end
         2'b01: return {32'd0, a} * {32'd0, b};
         default: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               return {r[31:0], q[31:0]};
            end
            uq = a / b;
            ur = a % b;
            return {ur, uq};
         end
      endcase
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] flags();
      return {bus.busy, bus.done, bus.hi_w_en, bus.lo_w_en};
   endfunction

   task automatic do_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1;
      bus.op    = op;
      bus.src_a = a;
      bus.src_b = b;
      tick();
      bus.start = 1'b0;
   endtask

   // Issues one operation and returns at the negedge of its result cycle.
   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      int busy_n, strobe_n;
      exp = model(op, a, b);
      do_start(op, a, b);
      if (op[1] && b != 32'd0) begin
         busy_n   = 0;
         strobe_n = 0;
         for (int k = 1; k <= 32; k++) begin
            if (bus.busy) busy_n++;
            if (bus.done || bus.hi_w_en || bus.lo_w_en) strobe_n++;
            if (k == inject_k) begin
               bus.start = 1'b1;
               bus.op    = 2'b01;
               bus.src_a = 32'd3;
               bus.src_b = 32'd4;
            end
            if (k == inject_k + 1) bus.start = 1'b0;
            tick();
         end
         check({tag, " busy cycles"}, busy_n, 32);
         check({tag, " early strobe"}, strobe_n, 0);
      end
      check({tag, " strobes"}, flags(), 4'b0111);
      check({tag, " hi/lo"}, {bus.hi_w_data, bus.lo_w_data}, exp);
   endtask

   initial begin
      int busy_n, strobe_n;
      logic [1:0]  r_op;
      logic [31:0] r_a, r_b;
      logic [63:0] held;
      checks    = 0;
      failures  = 0;
      inject_k  = 0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.cancel = 1'b0;
      bus.op    = 2'b00;
      bus.src_a = '0;
      bus.src_b = '0;
      tick();
      tick();
      check("reset flags", flags(), 4'b0000);
      check("reset data", {bus.hi_w_data, bus.lo_w_data}, 64'd0);
      reset = 1'b0;
      tick();

      run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("multu literal", {bus.hi_w_data, bus.lo_w_data}, 64'hFFFF_FFFE_0000_0001);
      held = {bus.hi_w_data, bus.lo_w_data};
      tick();
      check("after done flags", flags(), 4'b0000);
      check("after done data held", {bus.hi_w_data, bus.lo_w_data}, held);

      run_op("mult -2x3", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
      check("mult literal", {bus.hi_w_data, bus.lo_w_data}, 64'hFFFF_FFFF_FFFF_FFFA);
      tick();

      inject_k = 5;
      run_op("div -7/2 ignored start", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
      check("div literal", {bus.hi_w_data, bus.lo_w_data}, 64'hFFFF_FFFF_FFFF_FFFD);
      inject_k = 0;
      tick();

      run_op("divu by zero", 2'b11, 32'h0000_0064, 32'h0000_0000);
      tick();
      run_op("div by zero", 2'b10, 32'h8000_0001, 32'h0000_0000);
      tick();
      run_op("div overflow", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div overflow literal", {bus.hi_w_data, bus.lo_w_data}, 64'h0000_0000_8000_0000);
      tick();

      // Flush in the middle of a divide.
      do_start(2'b11, 32'd100, 32'd7);
      busy_n   = 0;
      strobe_n = 0;
      for (int k = 1; k <= 40; k++) begin
         if (k == 10) bus.cancel = 1'b1;
         if (k == 11) bus.cancel = 1'b0;
         if (k >= 11) begin
            if (bus.busy) busy_n++;
            if (bus.done || bus.hi_w_en || bus.lo_w_en) strobe_n++;
         end
         tick();
      end
      check("cancel busy after", busy_n, 0);
      check("cancel no strobe", strobe_n, 0);

      // Flush in the result cycle.
      do_start(2'b01, 32'd5, 32'd6);
      bus.cancel = 1'b1;
      #1;
      check("cancel in done", flags(), 4'b0000);
      tick();
      bus.cancel = 1'b0;
      #1;
      check("after cancel in done", flags(), 4'b0000);
      tick();

      // Reset in the middle of a divide.
      do_start(2'b11, 32'd1000, 32'd3);
      for (int k = 1; k < 20; k++) tick();
      check("busy before reset", flags(), 4'b1000);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("reset mid flags", flags(), 4'b0000);
      check("reset mid data", {bus.hi_w_data, bus.lo_w_data}, 64'd0);
      strobe_n = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.done || bus.hi_w_en || bus.lo_w_en || bus.busy) strobe_n++;
      end
      check("reset mid no activity", strobe_n, 0);

      // Back-to-back: the multiply starts in the divide's DONE cycle.
      run_op("b2b divu", 2'b11, 32'd100, 32'd7);
      check("b2b divu literal", {bus.hi_w_data, bus.lo_w_data}, {32'd2, 32'd14});
      run_op("b2b multu", 2'b01, 32'd3, 32'd4);
      check("b2b multu literal", {bus.hi_w_data, bus.lo_w_data}, {32'd0, 32'd12});
      tick();

      for (int i = 0; i < 40; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
         case ($urandom_range(0, 7))
            0:       r_b = 32'd0;
            1:       r_b = 32'hFFFF_FFFF;
            2:       r_b = 32'($urandom_range(1, 15));
            default: r_b = 32'($urandom);
         endcase
         run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b);
         if ($urandom_range(0, 1) == 1) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
